serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 7: bit-counter width, at least clog2(WIDTH+1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new addition; sampled only when ready=1.
REQ-006 SHALL have port a  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 SHALL have port b  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 SHALL have port c_in  input  1  carry into bit 0; captured on the accepting edge.
REQ-009 SHALL have port sub  input  1  subtract select (SERIAL_ADD_SUB_EN builds only).
REQ-010 SHALL have port ready  output  1  high in IDLE only.
REQ-011 SHALL have port busy  output  1  high in RUN only.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port sum  output  WIDTH  registered result.
REQ-014 SHALL have port c_out  output  1  carry out of bit WIDTH-1.
REQ-015 SHALL have port overflow  output  1  signed overflow: carry into MSB XOR c_out.

Function
REQ-016 SHALL instantiate exactly one full_adder cell; all bit sums SHALL come from it, LSB first, one bit per cycle.
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start&&ready; RUN->DONE after WIDTH bit cycles; DONE->IDLE after one cycle.
REQ-018 On the accepting edge SHALL load A/B shift registers, carry flop <= c_in, counter <= 0.
REQ-019 Each RUN edge SHALL shift A and B right by one bit, shift the cell's sum bit into sum from the MSB end, update the carry flop with the cell's carry out, and increment the counter.
REQ-020 SHALL reach DONE on the WIDTH-th edge after acceptance; done=1 for exactly that one cycle.
REQ-021 In DONE and afterwards, sum = (a+b+c_in) mod 2^WIDTH and c_out = bit WIDTH of that total.
REQ-022 sum, c_out and overflow SHALL hold their values until the next accepting edge; they SHALL not be cleared at DONE->IDLE.
REQ-023 While a new operation is in RUN, sum and the flags are undefined-in-progress; consumers SHALL sample only on done.
REQ-024 start while busy or in DONE SHALL be ignored with no queuing; a, b and c_in changes during RUN SHALL not affect the result.
REQ-025 With WIDTH=1, RUN SHALL last one cycle and overflow SHALL equal c_in XOR c_out.
REQ-026 Back-to-back operation: start held high SHALL be accepted on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, with ready=1, busy=0, done=0, sum=0, c_out=0, overflow=0, and the counter, carry flop and shift registers at 0.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro SERIAL_ADD_SUB_EN defined: port sub SHALL exist; with sub=1 at acceptance, B SHALL be loaded inverted and the carry flop loaded with 1 (c_in ignored), giving a-b.
REQ-030 Macro SERIAL_ADD_SUB_EN undefined: port sub SHALL be absent, and the block SHALL only add.

Verification
REQ-031 WIDTH=64, a=0, b=0, c_in=0, start pulse: done on the 64th edge after acceptance; sum=0, c_out=0, overflow=0.
REQ-032 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1: sum=0, c_out=1, overflow=0.
REQ-033 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, c_in=0: sum=64'h8000_0000_0000_0000, c_out=0, overflow=1.
REQ-034 start re-pulsed and a/b changed at RUN cycle 10: ignored; the original result is produced; exactly one done.
REQ-035 rst pulsed at RUN cycle 30: ready=1, sum=0, done never pulses; the next operation 3+4 gives sum=7.
REQ-036 SERIAL_ADD_SUB_EN defined, sub=1, a=5, b=7: sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built on a single full_adder cell.
// One operand bit pair is added per clock, LSB first. A result takes WIDTH RUN
// cycles followed by a one-cycle DONE pulse.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the 'sub' port for a-b operation.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // Operand B and initial carry as loaded on acceptance (inverted B and carry 1 for subtract)
  always_comb begin
    b_load = b;
    c_load = c_in;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // The one adder cell; every sum bit passes through it
  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status outputs track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Serial datapath: load on accept, shift one bit per RUN cycle, latch flags on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        c_out    <= fa_co;
        overflow <= carry ^ fa_co;
      end
    end
  end

endmodule

// Single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: behavioural model plus per-cycle compare,
// directed literal cases and randomized operations.
module tb_serial_add_ctrl;

  localparam int W  = 64;
  localparam int W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: n = -1 idle, 0..W-1 cycles into RUN, W = done cycle
  int           n = -1;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W:0]   pend = '0;
  logic         pend_ovf = 1'b0;
  logic [W-1:0] mx;
  logic [W-1:0] my;
  logic         mci;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (n < 0) begin
      if (start) begin
        mx = a; my = b; mci = c_in;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin my = ~b; mci = 1'b1; end
`endif
        pend     = {1'b0, mx} + {1'b0, my} + W1'(mci);
        pend_ovf = (mx[W-1] == my[W-1]) && (pend[W-1] != mx[W-1]);
        n = 0;
      end
    end else if (n == W) begin
      n = -1;
    end else begin
      n++;
      if (n == W) begin
        m_sum = pend[W-1:0]; m_cout = pend[W]; m_ovf = pend_ovf;
      end
    end
  end

  // Per-cycle compare; result values are only meaningful outside RUN
  always @(negedge clk) begin
    chkb("ready", ready, n < 0);
    chkb("busy", busy, (n >= 0) && (n < W));
    chkb("done", done, n == W);
    if (n < 0 || n == W) begin
      chk("sum", sum, m_sum);
      chkb("c_out", c_out, m_cout);
      chkb("overflow", overflow, m_ovf);
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready) return;
      @(posedge clk); #1;
    end
    chkb("ready_timeout", 1'b0, 1'b1);
  endtask

  // Drive one request and consume its accepting edge
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    wait_ready();
    a = x; b = y; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges until done is seen; optionally jiggle inputs meanwhile
  task automatic wait_done(output int cnt, input bit noisy);
    cnt = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt = i;
        if (noisy) start = 1'b0;
        return;
      end
      if (noisy) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c_in = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      end
    end
    chkb("done_timeout", 1'b0, 1'b1);
    start = 1'b0;
  endtask

  initial begin
    int k;
    int dcount;
    logic [W-1:0] keep;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_ready", ready, 1'b1);
    chk("rst_sum", sum, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0+0+0: done on the 64th edge after acceptance
    start_op('0, '0, 1'b0);
    wait_done(k, 1'b0);
    chki("zero_latency", k, W);
    chk("zero_sum", sum, 64'h0);
    chkb("zero_cout", c_out, 1'b0);
    chkb("zero_ovf", overflow, 1'b0);

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_done(k, 1'b0);
    chk("wrap_sum", sum, 64'h0);
    chkb("wrap_cout", c_out, 1'b1);
    chkb("wrap_ovf", overflow, 1'b0);

    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_done(k, 1'b0);
    chk("ovf_sum", sum, 64'h8000_0000_0000_0000);
    chkb("ovf_cout", c_out, 1'b0);
    chkb("ovf_ovf", overflow, 1'b1);

    // Results hold through IDLE
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", sum, 64'h8000_0000_0000_0000);

    // Restart and operand change mid-run are ignored
    start_op(64'd123, 64'd456, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    a = 64'd999; b = 64'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0; keep = '0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done) begin dcount++; keep = sum; end
    end
    chki("restart_dones", dcount, 1);
    chk("restart_sum", keep, 64'd579);

    // Reset mid-run aborts with no done
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chkb("abort_ready", ready, 1'b1);
    chk("abort_sum", sum, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chki("abort_dones", dcount, 0);
    start_op(64'd3, 64'd4, 1'b0);
    wait_done(k, 1'b0);
    chk("after_abort_sum", sum, 64'd7);

    // Back-to-back with start held high
    wait_ready();
    a = 64'd10; b = 64'd20; c_in = 1'b0; start = 1'b1;
    wait_done(k, 1'b0);
    wait_done(k, 1'b0);
    start = 1'b0;
    chki("b2b_period", k, W + 2);
    chk("b2b_sum", sum, 64'd30);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    start_op(64'd5, 64'd7, 1'b0);
    sub = 1'b0;
    wait_done(k, 1'b0);
    chk("sub_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chkb("sub_cout", c_out, 1'b0);
    chkb("sub_ovf", overflow, 1'b0);
`endif

    // Randomized operations with input noise during RUN
    for (int t = 0; t < 24; t++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (t % 6 == 1) x = 64'hFFFF_FFFF_FFFF_FFFF;
      if (t % 6 == 2) y = 64'h8000_0000_0000_0000;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      start_op(x, y, 1'($urandom_range(0, 1)));
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      wait_done(k, 1'b1);
      chki("rand_latency", k, W);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
